evp_instr_sched: RTL and testbench

Instruction scheduler for the polynomial evaluation accelerator. It pops 16-bit instructions from the instruction FIFO and decodes them. Store instructions are written into the N memory (degree table) and S memory (coefficient table). For evaluate instructions it drives the EVP unit's start/done handshake, owns the data-buffer read pointer, and pushes result/status words into the output FIFO. It sits between the host-facing FIFOs and the EVP FSM.

---
 rtl/evp_pkg.sv | 19 +
 rtl/evp_instr_sched.sv | 158 +++++++++++++++
 tb/tb_evp_instr_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/evp_pkg.sv
// evp_pkg: shared opcodes, scheduler states and constants for the polynomial evaluation accelerator
package evp_pkg;
    localparam logic [2:0] OP_RST = 3'd0;
    localparam logic [2:0] OP_STN = 3'd1;
    localparam logic [2:0] OP_STC = 3'd2;
    localparam logic [2:0] OP_EVP = 3'd3;
    localparam int MAX_DEG = 10;
    localparam int S_STRIDE = MAX_DEG + 1;
    localparam logic [15:0] ERR_TAG = 16'hFFFF;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, RST_CLR, STN_WR, STC_RD, STC_WR, EVP_RUN, OUT_RES, OUT_STAT, OUT_ERR
    } state_t;
    function automatic int log2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/evp_instr_sched.sv
// evp_instr_sched: pops instructions, writes N/S tables, runs the EVP start/done handshake, pushes results
// ports: instr_* instruction FIFO; data_wr_ptr/en_rd_data_c/data_in/rd_addr_data data buffer;
//        wr_*_N / wr_*_S table write ports; rst_instr/start_evp/A/done_evp/result/status/
//        rd_addr_data_updated EVP unit; out_full/out_wr_en/out_data output FIFO
module evp_instr_sched
    import evp_pkg::*;
#(
    parameter int buffer_size = 1024,
    parameter int max_deg = MAX_DEG,
    localparam int AW = log2(buffer_size)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_empty,
    output logic          instr_rd_en,
    input  logic [15:0]   instr_in,
    input  logic [AW-1:0] data_wr_ptr,
    output logic          en_rd_data_c,
    input  logic [15:0]   data_in,
    output logic [AW-1:0] rd_addr_data,
    output logic          wr_en_N,
    output logic [2:0]    wr_addr_N,
    output logic [4:0]    wr_data_N,
    output logic          wr_en_S,
    output logic [6:0]    wr_addr_S,
    output logic [15:0]   wr_data_S,
    output logic          rst_instr,
    output logic          start_evp,
    output logic [2:0]    A,
    input  logic          done_evp,
    input  logic [31:0]   result,
    input  logic [31:0]   status,
    input  logic [AW-1:0] rd_addr_data_updated,
    input  logic          out_full,
    output logic          out_wr_en,
    output logic [31:0]   out_data
);
    localparam logic [4:0] MD = 5'(max_deg);
    // A*11 + k built from shifts so no multiplier is inferred
    function automatic logic [6:0] s_addr(input logic [2:0] a, input logic [3:0] k);
        return {1'b0, a, 3'b000} + {3'b000, a, 1'b0} + {4'b0000, a} + {3'b000, k};
    endfunction
    state_t state;
    logic [31:0] stat_r;
    logic [2:0] op, a;
    logic n_bad, k_bad, avail, unused_bits;
    assign op = instr_in[15:13];
    assign a = instr_in[12:10];
    assign n_bad = instr_in[9:5] > MD;
    assign k_bad = {1'b0, instr_in[9:6]} > MD;
    assign avail = rd_addr_data != data_wr_ptr;
    assign unused_bits = ^instr_in[4:0];
    // push strobe is gated live by out_full so a FIFO that fills mid-word is never overrun
    assign out_wr_en = (state == OUT_RES || state == OUT_STAT || state == OUT_ERR) && !out_full;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            instr_rd_en <= 1'b0;
            en_rd_data_c <= 1'b0;
            rd_addr_data <= '0;
            wr_en_N <= 1'b0;
            wr_addr_N <= '0;
            wr_data_N <= '0;
            wr_en_S <= 1'b0;
            wr_addr_S <= '0;
            wr_data_S <= '0;
            rst_instr <= 1'b0;
            start_evp <= 1'b0;
            A <= '0;
            out_data <= '0;
            stat_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_en_S <= 1'b0;
                    if (!instr_empty) begin
                        instr_rd_en <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    instr_rd_en <= 1'b0;
                    state <= DECODE;
                end
                // instr_in stays stable here because nothing pops until the next FETCH
                DECODE: begin
                    if (op == OP_RST) begin
                        rst_instr <= 1'b1;
                        wr_en_N <= 1'b1;
                        wr_addr_N <= '0;
                        wr_data_N <= '0;
                        state <= RST_CLR;
                    end else if (op == OP_STN && !n_bad) begin
                        wr_en_N <= 1'b1;
                        wr_addr_N <= a;
                        wr_data_N <= instr_in[9:5];
                        state <= STN_WR;
                    end else if (op == OP_STC && !k_bad) begin
                        if (avail) begin
                            en_rd_data_c <= 1'b1;
                            wr_addr_S <= s_addr(a, instr_in[9:6]);
                            state <= STC_RD;
                        end
                    end else if (op == OP_EVP) begin
                        if (avail) begin
                            start_evp <= 1'b1;
                            A <= a;
                            state <= EVP_RUN;
                        end
                    end else begin
                        out_data <= {ERR_TAG, 13'd0, op};
                        state <= OUT_ERR;
                    end
                end
                RST_CLR: begin
                    rst_instr <= 1'b0;
                    if (wr_addr_N == 3'd7) begin
                        wr_en_N <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wr_addr_N <= wr_addr_N + 3'd1;
                    end
                end
                STN_WR: begin
                    wr_en_N <= 1'b0;
                    state <= IDLE;
                end
                STC_RD: begin
                    en_rd_data_c <= 1'b0;
                    rd_addr_data <= rd_addr_data + AW'(1);
                    state <= STC_WR;
                end
                STC_WR: begin
                    wr_en_S <= 1'b1;
                    wr_data_S <= data_in;
                    state <= IDLE;
                end
                EVP_RUN: begin
                    if (done_evp) begin
                        start_evp <= 1'b0;
                        out_data <= result;
                        stat_r <= status;
                        rd_addr_data <= rd_addr_data_updated;
                        state <= OUT_RES;
                    end
                end
                OUT_RES: begin
                    if (!out_full) begin
                        out_data <= stat_r;
                        state <= OUT_STAT;
                    end
                end
                OUT_STAT, OUT_ERR: state <= out_full ? state : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_evp_instr_sched.sv
// tb_evp_instr_sched: table-driven and sequence checks of the scheduler against FIFO, memory and EVP models
module tb_evp_instr_sched;
    import evp_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic instr_empty, instr_rd_en, en_rd_data_c, wr_en_N, wr_en_S, rst_instr, start_evp;
    logic done_evp, out_full, out_wr_en;
    logic [15:0] instr_in, data_in, wr_data_S;
    logic [9:0] data_wr_ptr, rd_addr_data, upd;
    logic [2:0] wr_addr_N, A;
    logic [4:0] wr_data_N;
    logic [6:0] wr_addr_S;
    logic [31:0] result, status, out_data;
    always #5 clk = ~clk;

    evp_instr_sched dut (
        .clk(clk), .rst(rst), .instr_empty(instr_empty), .instr_rd_en(instr_rd_en),
        .instr_in(instr_in), .data_wr_ptr(data_wr_ptr), .en_rd_data_c(en_rd_data_c),
        .data_in(data_in), .rd_addr_data(rd_addr_data), .wr_en_N(wr_en_N),
        .wr_addr_N(wr_addr_N), .wr_data_N(wr_data_N), .wr_en_S(wr_en_S),
        .wr_addr_S(wr_addr_S), .wr_data_S(wr_data_S), .rst_instr(rst_instr),
        .start_evp(start_evp), .A(A), .done_evp(done_evp), .result(result),
        .status(status), .rd_addr_data_updated(upd), .out_full(out_full),
        .out_wr_en(out_wr_en), .out_data(out_data)
    );

    int vecs = 0, miss = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // instruction FIFO model
    logic [15:0] ibuf [256];
    int iwp = 0, irp = 0;
    assign instr_empty = (iwp == irp);
    always @(posedge clk) if (instr_rd_en) begin
        instr_in <= ibuf[irp[7:0]];
        irp <= irp + 1;
    end

    // data buffer model
    logic [15:0] dbuf [1024];
    logic [9:0] wp = '0;
    assign data_wr_ptr = wp;
    always @(posedge clk) if (en_rd_data_c) data_in <= dbuf[rd_addr_data];

    // N and S table models
    logic [4:0] nm [8];
    logic [15:0] sm [128];
    int n_wr = 0, s_wr = 0;
    always @(posedge clk) begin
        if (wr_en_N) begin
            nm[wr_addr_N] <= wr_data_N;
            n_wr <= n_wr + 1;
        end
        if (wr_en_S) begin
            sm[wr_addr_S] <= wr_data_S;
            s_wr <= s_wr + 1;
        end
    end

    // behavioural EVP unit: ascending coefficients, one data word consumed
    function automatic logic [31:0] peval(input logic [2:0] a, input logic [15:0] x);
        logic [31:0] r = 0, p = 1;
        for (int i = 0; i <= int'(nm[a]); i++) begin
            r += 32'(sm[int'(a) * 11 + i]) * p;
            p *= 32'(x);
        end
        return r;
    endfunction
    logic evp_hold = 1'b0;
    int ecnt = 0;
    always @(posedge clk) begin
        done_evp <= 1'b0;
        if (!start_evp) ecnt <= 0;
        else if (!done_evp && !evp_hold) begin
            if (ecnt == 3) begin
                done_evp <= 1'b1;
                result <= peval(A, dbuf[rd_addr_data]);
                status <= 32'd0;
                upd <= rd_addr_data + 10'd1;
                ecnt <= 0;
            end else ecnt <= ecnt + 1;
        end
    end

    // output FIFO scoreboard
    logic [31:0] expq [$];
    int npush = 0, ri_cnt = 0;
    always @(negedge clk) begin
        if (rst_instr) ri_cnt++;
        if (out_wr_en) begin
            npush++;
            if (expq.size() == 0) begin
                vecs++;
                miss++;
                $display("FAIL unexpected_push got=%0h want=none", out_data);
            end else chk("out_word", {32'd0, out_data}, {32'd0, expq.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic push_i(input logic [15:0] v);
        ibuf[iwp[7:0]] = v;
        iwp++;
    endtask
    task automatic push_d(input logic [15:0] v);
        dbuf[wp] = v;
        wp = wp + 10'd1;
    endtask
    function automatic logic [15:0] f_stn(input logic [2:0] a, input logic [4:0] n);
        return {OP_STN, a, n, 5'd0};
    endfunction
    function automatic logic [15:0] f_stc(input logic [2:0] a, input logic [3:0] k);
        return {OP_STC, a, k, 6'd0};
    endfunction
    function automatic logic [15:0] f_evp(input logic [2:0] a);
        return {OP_EVP, a, 10'd0};
    endfunction

    typedef struct {
        logic [15:0] ins;
        logic [15:0] d;
        int kind;
        int addr;
        logic [31:0] val;
    } vec_t;
    vec_t tbl [12];
    int n0, s0, p0, r0, hi, bad;
    logic [9:0] exp_rp;

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{f_stn(3'd0, 5'd3),  16'd0,      0, 0,  32'd3};
        tbl[1]  = '{f_stc(3'd0, 4'd0),  16'd3,      1, 0,  32'd3};
        tbl[2]  = '{f_stc(3'd0, 4'd1),  16'd4,      1, 1,  32'd4};
        tbl[3]  = '{f_stc(3'd0, 4'd2),  16'd2,      1, 2,  32'd2};
        tbl[4]  = '{f_stc(3'd0, 4'd3),  16'd1,      1, 3,  32'd1};
        tbl[5]  = '{f_stc(3'd7, 4'd10), 16'hBEEF,   1, 87, 32'hBEEF};
        tbl[6]  = '{f_stn(3'd2, 5'd11), 16'd0,      2, 0,  32'hFFFF0001};
        tbl[7]  = '{f_stc(3'd1, 4'd12), 16'd0,      2, 0,  32'hFFFF0002};
        tbl[8]  = '{16'hE000,           16'd0,      2, 0,  32'hFFFF0007};
        tbl[9]  = '{f_stn(3'd5, 5'd10), 16'd0,      0, 5,  32'd10};
        tbl[10] = '{f_stc(3'd5, 4'd1),  16'h1234,   1, 56, 32'h1234};
        tbl[11] = '{16'h8000,           16'd0,      2, 0,  32'hFFFF0004};
        for (int i = 0; i < 8; i++) nm[i] = '0;
        for (int i = 0; i < 128; i++) sm[i] = '0;
        exp_rp = '0;
        out_full = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_strobes", {instr_rd_en, en_rd_data_c, wr_en_N, wr_en_S, rst_instr, start_evp, out_wr_en}, 0);
        chk("reset_addrs", {rd_addr_data, wr_addr_N, wr_addr_S, A}, 0);
        chk("reset_data", {wr_data_N, wr_data_S, out_data}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            n0 = n_wr;
            s0 = s_wr;
            p0 = npush;
            if (tbl[i].kind == 1) push_d(tbl[i].d);
            if (tbl[i].kind == 2) expq.push_back(tbl[i].val);
            push_i(tbl[i].ins);
            repeat (20) tick();
            if (tbl[i].kind == 1) exp_rp = exp_rp + 10'd1;
            chk($sformatf("v%0d_n_writes", i), 64'(n_wr - n0), 64'(tbl[i].kind == 0));
            chk($sformatf("v%0d_s_writes", i), 64'(s_wr - s0), 64'(tbl[i].kind == 1));
            chk($sformatf("v%0d_pushes", i), 64'(npush - p0), 64'(tbl[i].kind == 2));
            if (tbl[i].kind == 0) chk($sformatf("v%0d_n_val", i), 64'(nm[tbl[i].addr]), 64'(tbl[i].val));
            if (tbl[i].kind == 1) chk($sformatf("v%0d_s_val", i), 64'(sm[tbl[i].addr]), 64'(tbl[i].val));
            chk($sformatf("v%0d_rd_ptr", i), 64'(rd_addr_data), 64'(exp_rp));
        end

        // evaluate slot 0 at x=2: 3 + 4*2 + 2*4 + 1*8 = 27
        p0 = npush;
        push_d(16'd2);
        expq.push_back(32'd27);
        expq.push_back(32'd0);
        push_i(f_evp(3'd0));
        for (int t = 0; t < 100 && (npush - p0) < 2; t++) tick();
        chk("evp_pushes", 64'(npush - p0), 2);
        exp_rp = exp_rp + 10'd1;
        chk("evp_rd_ptr", 64'(rd_addr_data), 64'(exp_rp));

        // no data: must stall; then full output FIFO at result time
        out_full = 1'b1;
        p0 = npush;
        hi = 0;
        push_i(f_evp(3'd0));
        repeat (10) begin
            tick();
            if (start_evp) hi++;
        end
        chk("stall_no_start", 64'(hi), 0);
        push_d(16'd1);
        expq.push_back(32'd10);
        expq.push_back(32'd0);
        for (int t = 0; t < 50 && !done_evp; t++) tick();
        chk("done_seen", 64'(done_evp), 1);
        chk("start_at_done", 64'(start_evp), 1);
        tick();
        chk("start_after_done", 64'(start_evp), 0);
        bad = 0;
        repeat (5) begin
            if (out_wr_en || out_data !== 32'd10) bad++;
            tick();
        end
        chk("full_hold", 64'(bad), 0);
        out_full = 1'b0;
        for (int t = 0; t < 20 && (npush - p0) < 2; t++) tick();
        repeat (5) tick();
        chk("release_pushes", 64'(npush - p0), 2);
        exp_rp = exp_rp + 10'd1;
        chk("stall_rd_ptr", 64'(rd_addr_data), 64'(exp_rp));

        // reset in the middle of EVP_RUN
        evp_hold = 1'b1;
        push_d(16'd5);
        push_i(f_evp(3'd3));
        for (int t = 0; t < 50 && !start_evp; t++) tick();
        chk("evp_started", {start_evp, A}, {1'b1, 3'd3});
        p0 = npush;
        rst = 1'b1;
        #1;
        chk("midrst_strobes", {instr_rd_en, en_rd_data_c, wr_en_N, wr_en_S, rst_instr, start_evp, out_wr_en}, 0);
        chk("midrst_addrs", {rd_addr_data, wr_addr_N, wr_addr_S, A, out_data}, 0);
        tick();
        rst = 1'b0;
        evp_hold = 1'b0;
        exp_rp = '0;
        repeat (10) tick();
        chk("no_push_after_rst", 64'(npush - p0), 0);

        // RST instruction clears all of N with one rst_instr pulse
        n0 = n_wr;
        r0 = ri_cnt;
        push_i(16'h0000);
        repeat (20) tick();
        chk("rst_n_writes", 64'(n_wr - n0), 8);
        chk("rst_instr_cycles", 64'(ri_cnt - r0), 1);
        chk("n_cleared", {nm[0], nm[1], nm[2], nm[3], nm[4], nm[5], nm[6], nm[7]}, 0);
        chk("expq_drained", 64'(expq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
